// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the unified-memory arbiter.
//   arb_state_e : FSM state encoding (IDLE / ACCESS / DONE)
//   arb_owner_e : which pipeline port owns the current access
//   CNT_W       : width of the wait and starve counters (both cover 0..15)
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_F = 1'b0,
    ARB_OWN_D = 1'b1
  } arb_owner_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_pick.sv
// mem_arb_pick: grant selection and next starve-counter value.
//   arb_en     in  1      arbitration slot (FSM in IDLE)
//   IReq/DReq  in  1      port requests
//   starve     in  CNT_W  current starve count
//   grant      out        winning port (meaningful when grant_vld)
//   grant_vld  out  1     a grant is made this cycle
//   starve_nxt out  CNT_W value to register as the new starve count
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             arb_en,
  input  logic             IReq,
  input  logic             DReq,
  input  logic [CNT_W-1:0] starve,
  output arb_owner_e       grant,
  output logic             grant_vld,
  output logic [CNT_W-1:0] starve_nxt
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

  logic starved;
  assign starved = (starve == LIM);

  always_comb begin
    // Data wins by default; fetch only wins alone or once it has been starved.
    grant = ARB_OWN_D;
    if (IReq && (!DReq || starved)) grant = ARB_OWN_F;
    grant_vld  = arb_en & (IReq | DReq);
    starve_nxt = starve;
    if (arb_en) begin
      if (!IReq || grant == ARB_OWN_F) starve_nxt = '0;
      else if (!starved)               starve_nxt = starve + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported Memory between fetch and MEM stages.
//   CLK, RST            clock, synchronous active-high reset
//   IReq/IAddr          fetch request and address; IRdata/IReady result
//   DReq/DWe/DAddr/DWdata  data request; DRdata/DReady result
//   MemA/MemWD/MemWE    Memory address, write data, write enable
//   MemRD               Memory read data
//   StallF/StallM       stall requests to the hazard unit
// Each access: grant in IDLE, WAIT_CYCLES+1 ACCESS cycles with MemA/MemWD
// held, one DONE cycle pulsing the owner's Ready.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IRdata,
  output logic        IReady,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWdata,
  output logic [31:0] DRdata,
  output logic        DReady,
  output logic [31:0] MemA,
  output logic [31:0] MemWD,
  output logic        MemWE,
  input  logic [31:0] MemRD,
  output logic        StallF,
  output logic        StallM
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic             NO_WAIT   = (WAIT_CYCLES == 0);

  arb_state_e       state;
  arb_owner_e       owner;
  arb_owner_e       grant;
  logic             grant_vld;
  logic             we_l;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] starve, starve_nxt;

  mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .arb_en    (state == ARB_IDLE),
    .IReq      (IReq),
    .DReq      (DReq),
    .starve    (starve),
    .grant     (grant),
    .grant_vld (grant_vld),
    .starve_nxt(starve_nxt)
  );

  assign StallF = IReq & ~IReady;
  assign StallM = DReq & ~DReady;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ARB_IDLE;
      owner  <= ARB_OWN_F;
      we_l   <= 1'b0;
      cnt    <= '0;
      starve <= '0;
      MemA   <= '0;
      MemWD  <= '0;
      MemWE  <= 1'b0;
      IRdata <= '0;
      DRdata <= '0;
      IReady <= 1'b0;
      DReady <= 1'b0;
    end else begin
      starve <= starve_nxt;
      MemWE  <= 1'b0;
      IReady <= 1'b0;
      DReady <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_vld) begin
            owner <= grant;
            we_l  <= (grant == ARB_OWN_D) & DWe;
            MemA  <= (grant == ARB_OWN_D) ? DAddr : IAddr;
            if (grant == ARB_OWN_D) MemWD <= DWdata;
            cnt   <= WAIT_INIT;
            // With no wait states the first ACCESS cycle is already the write cycle.
            MemWE <= NO_WAIT & (grant == ARB_OWN_D) & DWe;
            state <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (cnt == '0) begin
            state <= ARB_DONE;
            if (owner == ARB_OWN_D) begin
              DReady <= 1'b1;
              if (!we_l) DRdata <= MemRD;
            end else begin
              IReady <= 1'b1;
              IRdata <= MemRD;
            end
          end else begin
            cnt <= cnt - 1'b1;
            // Registered write enable lands in the counter=0 cycle only.
            if (cnt == 1) MemWE <= we_l;
          end
        end
        ARB_DONE: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven + scoreboard bench for mem_arbiter.
module tb_mem_arbiter;

  localparam int W = 2;

  typedef struct {
    bit          chk;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq, dreq, dwe;
  logic [31:0] iaddr, daddr, dwdata;
  logic [31:0] irdata, drdata, mem_a, mem_wd, mem_rd;
  logic        iready, dready, mem_we, stall_f, stall_m;

  logic        ireq_z, dreq_z, dwe_z;
  logic [31:0] iaddr_z, daddr_z, dwdata_z;
  logic [31:0] irdata_z, drdata_z, mem_a_z, mem_wd_z, mem_rd_z;
  logic        iready_z, dready_z, mem_we_z, stall_f_z, stall_m_z;

  logic [31:0] mem [16] = '{0: 32'h2008_0005, 1: 32'h0BAD_C0DE, 14: 32'hCAFE_F00D, default: 32'h0};

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   we_cnt, we_cyc, sf_cnt, sm_cnt, t0;
  exp_t iq[$];
  exp_t dq[$];
  vec_t vt[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mem_we) mem[mem_a[5:2]] <= mem_wd;

  assign mem_rd   = mem[mem_a[5:2]];
  assign mem_rd_z = mem[mem_a_z[5:2]];

  mem_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(4)) dut (
    .CLK(clk), .RST(rst),
    .IReq(ireq), .IAddr(iaddr), .IRdata(irdata), .IReady(iready),
    .DReq(dreq), .DWe(dwe), .DAddr(daddr), .DWdata(dwdata),
    .DRdata(drdata), .DReady(dready),
    .MemA(mem_a), .MemWD(mem_wd), .MemWE(mem_we), .MemRD(mem_rd),
    .StallF(stall_f), .StallM(stall_m)
  );

  mem_arbiter #(.WAIT_CYCLES(0), .STARVE_LIMIT(4)) dut_z (
    .CLK(clk), .RST(rst),
    .IReq(ireq_z), .IAddr(iaddr_z), .IRdata(irdata_z), .IReady(iready_z),
    .DReq(dreq_z), .DWe(dwe_z), .DAddr(daddr_z), .DWdata(dwdata_z),
    .DRdata(drdata_z), .DReady(dready_z),
    .MemA(mem_a_z), .MemWD(mem_wd_z), .MemWE(mem_we_z), .MemRD(mem_rd_z),
    .StallF(stall_f_z), .StallM(stall_m_z)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called once per cycle, just after the negedge: scoreboard pops and
  // requester behaviour (drop Req once its last expected completion arrives).
  task automatic sample();
    exp_t e;
    if (mem_we) begin we_cnt++; we_cyc = cyc; end
    if (stall_f) sf_cnt++;
    if (stall_m) sm_cnt++;
    if (iready) begin
      if (iq.size() == 0) begin
        total++; bad++;
        $display("FAIL iready_unexpected: got pulse want none (cycle %0d)", cyc);
      end else begin
        e = iq.pop_front();
        chk("iready_cycle", cyc, e.cyc);
        if (e.chk) chk("irdata", irdata, e.data);
        if (iq.size() == 0) ireq = 1'b0;
      end
    end
    if (dready) begin
      if (dq.size() == 0) begin
        total++; bad++;
        $display("FAIL dready_unexpected: got pulse want none (cycle %0d)", cyc);
      end else begin
        e = dq.pop_front();
        chk("dready_cycle", cyc, e.cyc);
        if (e.chk) chk("drdata", drdata, e.data);
        if (dq.size() == 0) dreq = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1 sample();
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((iq.size() != 0 || dq.size() != 0) && n < lim) begin
      step();
      n++;
    end
    if (iq.size() != 0 || dq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got pending i=%0d d=%0d want 0", iq.size(), dq.size());
      iq.delete(); dq.delete();
      ireq = 1'b0; dreq = 1'b0;
    end
  endtask

  task automatic issue(input vec_t v);
    exp_t e;
    @(negedge clk);
    we_cnt = 0; sf_cnt = 0; sm_cnt = 0; t0 = cyc;
    e.chk  = !v.we;
    e.data = v.rdata;
    e.cyc  = cyc + W + 2;
    if (v.d) begin
      dreq = 1'b1; dwe = v.we; daddr = v.addr; dwdata = v.wdata;
      dq.push_back(e);
    end else begin
      ireq = 1'b1; iaddr = v.addr;
      iq.push_back(e);
    end
    #1 sample();
    drain(30);
  endtask

  initial begin
    exp_t e;
    vt[0] = '{d: 0, we: 0, addr: 32'h0040_0000, wdata: 32'h0,         rdata: 32'h2008_0005};
    vt[1] = '{d: 1, we: 1, addr: 32'h7FFF_FFFC, wdata: 32'hDEAD_BEEF, rdata: 32'h0};
    vt[2] = '{d: 1, we: 0, addr: 32'h7FFF_FFFC, wdata: 32'h0,         rdata: 32'hDEAD_BEEF};
    vt[3] = '{d: 0, we: 0, addr: 32'h0040_0004, wdata: 32'h0,         rdata: 32'h0BAD_C0DE};
    vt[4] = '{d: 1, we: 1, addr: 32'h0000_1010, wdata: 32'hA5A5_A5A5, rdata: 32'h0};
    vt[5] = '{d: 1, we: 0, addr: 32'h0000_1010, wdata: 32'h0,         rdata: 32'hA5A5_A5A5};
    vt[6] = '{d: 0, we: 0, addr: 32'h0040_0000, wdata: 32'h0,         rdata: 32'h2008_0005};

    rst = 1'b1;
    ireq = 0; dreq = 0; dwe = 0; iaddr = 0; daddr = 0; dwdata = 0;
    ireq_z = 0; dreq_z = 0; dwe_z = 0; iaddr_z = 0; daddr_z = 0; dwdata_z = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    chk("rst_irdata", irdata, 32'h0);
    chk("rst_drdata", drdata, 32'h0);
    chk("rst_flags", {mem_we, iready, dready}, 32'h0);
    rst = 1'b0;
    step();

    // Single accesses from the table.
    for (int k = 0; k < 7; k++) begin
      issue(vt[k]);
      chk($sformatf("v%0d_we_count", k), we_cnt, vt[k].we ? 32'd1 : 32'd0);
      if (vt[k].we) chk($sformatf("v%0d_we_cycle", k), we_cyc, t0 + W + 1);
      chk($sformatf("v%0d_stall", k), vt[k].d ? sm_cnt : sf_cnt, W + 2);
    end

    // Both ports rise together: data first, fetch in the next slot.
    @(negedge clk);
    sf_cnt = 0; sm_cnt = 0; we_cnt = 0; t0 = cyc;
    ireq = 1; iaddr = 32'h0040_0004;
    dreq = 1; dwe = 0; daddr = 32'h7FFF_FFFC;
    e = '{chk: 1, data: 32'hDEAD_BEEF, cyc: t0 + 4}; dq.push_back(e);
    e = '{chk: 1, data: 32'h0BAD_C0DE, cyc: t0 + 9}; iq.push_back(e);
    #1 sample();
    drain(40);
    chk("both_stallf", sf_cnt, 32'd9);
    chk("both_we_count", we_cnt, 32'd0);

    // Starvation: four data grants, then fetch forced, then data resumes.
    @(negedge clk);
    sf_cnt = 0; t0 = cyc;
    ireq = 1; iaddr = 32'h0040_0000;
    dreq = 1; dwe = 0; daddr = 32'h0000_1010;
    foreach (vt[k]) if (k < 4) begin
      e = '{chk: 1, data: 32'hA5A5_A5A5, cyc: t0 + 4 + 5 * k}; dq.push_back(e);
    end
    e = '{chk: 1, data: 32'h2008_0005, cyc: t0 + 24}; iq.push_back(e);
    e = '{chk: 1, data: 32'hA5A5_A5A5, cyc: t0 + 29}; dq.push_back(e);
    #1 sample();
    drain(60);
    chk("starve_stallf", sf_cnt, 32'd24);

    // Reset in the middle of a store.
    @(negedge clk);
    we_cnt = 0; t0 = cyc;
    dreq = 1; dwe = 1; daddr = 32'h7FFF_FFF8; dwdata = 32'h1234_5678;
    #1 sample();
    step();
    step();
    rst = 1; dreq = 0;
    step();
    chk("midrst_mem_a", mem_a, 32'h0);
    chk("midrst_mem_wd", mem_wd, 32'h0);
    chk("midrst_irdata", irdata, 32'h0);
    chk("midrst_drdata", drdata, 32'h0);
    chk("midrst_flags", {mem_we, iready, dready, stall_f, stall_m}, 32'h0);
    rst = 0;
    repeat (6) step();
    chk("midrst_we_count", we_cnt, 32'd0);
    chk("midrst_word", mem[14], 32'hCAFE_F00D);

    // Zero wait states: load completes two cycles after the request.
    @(negedge clk);
    t0 = cyc;
    dreq_z = 1; dwe_z = 0; daddr_z = 32'h0040_0004;
    #1 chk("w0_t_ready", dready_z, 1'b0);
    @(negedge clk); #1;
    chk("w0_t1_mem_a", mem_a_z, 32'h0040_0004);
    chk("w0_t1_ready", dready_z, 1'b0);
    @(negedge clk); #1;
    chk("w0_t2_ready", dready_z, 1'b1);
    chk("w0_t2_cycle", cyc, t0 + 2);
    chk("w0_drdata", drdata_z, 32'h0BAD_C0DE);
    dreq_z = 0;
    @(negedge clk); #1;
    chk("w0_t3_ready", dready_z, 1'b0);
    chk("w0_we", mem_we_z, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-ported unified Memory between the fetch stage (instruction port) and the MEM stage (data port).
- Sequences each access over a programmable number of wait states and returns read data on a one-cycle Ready pulse.
- Generates StallF/StallM for the hazard unit while a port waits.
- Sits between the pipeline registers and the Memory instance, which captures address and write data on negedge CLK.

Parameters:
- WAIT_CYCLES, 2: extra access cycles beyond the first. Legal range 0..15.
- STARVE_LIMIT, 4: maximum consecutive data grants while IReq is pending. Legal range 1..15.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- IReq  in  1  fetch request; held until IReady.
- IAddr  in  32  fetch byte address.
- IRdata  out  32  fetched word; valid when IReady=1, held until the next fetch completion.
- IReady  out  1  one-cycle completion pulse, fetch port.
- DReq  in  1  data request; held until DReady.
- DWe  in  1  1=write, 0=read; qualified by DReq.
- DAddr  in  32  data byte address.
- DWdata  in  32  store data.
- DRdata  out  32  load data; valid when DReady=1, held until the next data completion.
- DReady  out  1  one-cycle completion pulse, data port.
- MemA  out  32  address to Memory.
- MemWD  out  32  write data to Memory.
- MemWE  out  1  write enable to Memory.
- MemRD  in  32  read data from Memory.
- StallF  out  1  IReq & ~IReady (combinational).
- StallM  out  1  DReq & ~DReady (combinational).

Behaviour:
- Reset (sync, RST=1 at posedge): state=IDLE, wait counter=0, starve counter=0, owner=fetch. MemA, MemWD, IRdata, DRdata = 0. MemWE, IReady, DReady = 0.
- FSM IDLE, no request: stay IDLE.
- FSM IDLE, any request: arbitrate, then
  - latch owner, address, write data and we (we is forced 0 for fetch);
  - load wait counter with WAIT_CYCLES;
  - go to ACCESS.
- FSM ACCESS:
  - MemA and MemWD are driven from latches and held constant for all WAIT_CYCLES+1 cycles.
  - Counter decrements each cycle. At counter=0, go to DONE.
  - MemWE=1 only in the counter=0 cycle, and only if the latched we=1. This gives exactly one write per store.
  - MemRD is sampled into the owner's Rdata register at the posedge ending the counter=0 cycle; reads only.
- FSM DONE: owner's Ready=1 for exactly this cycle, then IDLE.
  - Requests are not arbitrated in DONE.
  - A requester keeping Req high after Ready issues a new access, arbitrated in the following IDLE.
- Latency: Req seen in IDLE at cycle t gives Ready at cycle t+WAIT_CYCLES+2. Throughput is one access per WAIT_CYCLES+3 cycles.
- Arbitration: data port wins by default.
  - Starve counter increments (saturating at STARVE_LIMIT) on each data grant made while IReq=1.
  - Starve counter clears on any fetch grant, or in any IDLE cycle with IReq=0.
  - If both requests are present and starve counter = STARVE_LIMIT, fetch wins.
- Req dropped mid-access (protocol violation): the access completes and Ready still pulses. A write is never cancelled.
- Inputs changing during ACCESS: no effect, because everything is latched at grant.
- Reset mid-access: returns to IDLE at that edge. A pending write is never issued (MemWE stays 0) and no Ready pulses.
- Address alignment and range checks stay in Memory. The arbiter passes addresses unmodified.
- Idle cycles: MemWE=0; MemA/MemWD hold their last values.

Decomposition:
- Shared header (mips.h style, `define constants):
  - state encodings ARB_IDLE=2'd0, ARB_ACCESS=2'd1, ARB_DONE=2'd2;
  - owner encodings ARB_OWN_F=1'b0, ARB_OWN_D=1'b1.
- One sub-module, mem_arb_pick:
  - inputs: IReq, DReq, starve counter;
  - output: the grant;
  - also updates the saturating starve counter.
- FSM, wait counter and datapath latches stay in mem_arbiter.

Test Plan:
- Fetch read, IAddr=0x0040_0000, text word preloaded 0x2008_0005, WAIT_CYCLES=2, IReq rises at t -> IReady=1 only at t+4, IRdata=0x2008_0005, StallF=1 for t..t+3, MemWE never 1.
- Store DAddr=0x7FFF_FFFC, DWdata=0xDEAD_BEEF at t -> MemWE=1 only in t+3, DReady at t+4. Then a load from the same address -> DRdata=0xDEAD_BEEF.
- IReq and DReq both rise at t -> DReady at t+4, IReady at t+9, StallF high t..t+8.
- IReq held, DReq re-asserted after every DReady -> exactly 4 data completions, then one fetch completion, then data resumes.
- Store of 0x1234_5678 to 0x7FFF_FFF8 with RST=1 at t+2 -> MemWE never asserted, word unchanged, no Ready pulses, all outputs 0 after t+2.
- WAIT_CYCLES=0, single data load at t -> DReady at t+2, MemA valid in cycle t+1 only.
